// File: rtl/vga_pkg.sv
// Shared VGA definitions for the pixel pipeline.
// Holds the active-area geometry (also used by the display driver), the
// 12-bit colour type, the sprite direction encoding and the sprite palette.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [11:0] rgb12_t;

    // Encoded as {dx, dy}: dx=1 means moving left, dy=1 means moving up.
    typedef enum logic [1:0] {
        DR = 2'b00,
        UR = 2'b01,
        DL = 2'b10,
        UL = 2'b11
    } dir_t;

    // Colour cycled on every bounce, indexed by a 2-bit colour index.
    localparam rgb12_t PALETTE [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF};

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing sprite: position, direction, clamp and flip.
// Ports:
//   clk    pixel clock
//   reset  synchronous active-low reset (position 0, moving toward LIMIT)
//   upd    one-cycle update strobe from the frame divider
//   pos    current position (top/left edge of the sprite on this axis)
//   flip   combinational: this update reflects off an edge (only with upd)
module bounce_axis #(
    parameter int LIMIT = 608,
    parameter int STEP  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upd,
    output logic [9:0] pos,
    output logic       flip
);

    logic [9:0]  pos_q, pos_d;
    logic        neg_q, neg_d;   // 1 = moving toward 0
    logic [10:0] sum;            // 11 bits so the forward step can never wrap

    always_comb begin
        sum   = {1'b0, pos_q} + 11'(STEP);
        pos_d = pos_q;
        neg_d = neg_q;
        flip  = 1'b0;
        if (upd) begin
            if (!neg_q) begin
                if (sum >= 11'(LIMIT)) begin
                    pos_d = 10'(LIMIT);
                    neg_d = 1'b1;
                    flip  = 1'b1;
                end else begin
                    pos_d = sum[9:0];
                end
            end else begin
                // Clamp at 0 before subtracting so the position never underflows.
                if ({1'b0, pos_q} <= 11'(STEP)) begin
                    pos_d = '0;
                    neg_d = 1'b0;
                    flip  = 1'b1;
                end else begin
                    pos_d = pos_q - 10'(STEP);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_q <= '0;
            neg_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            neg_q <= neg_d;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/bounce_sprite.sv
// Bouncing-rectangle pixel colour generator for the VGA display driver.
// The colour path is combinational from row/col so it lines up with the
// driver's same-cycle sampling; motion state advances once per FRAME_DIV
// frames on the last active pixel, i.e. just before blanking.
// Ports:
//   clk     pixel clock shared with the display driver
//   reset   synchronous active-low reset
//   enable  1 = motion runs, 0 = sprite frozen
//   row     active-area row (0..V_ACTIVE-1)
//   col     active-area column (0..H_ACTIVE-1)
//   rgb     colour for the current pixel
//   bounce  one-cycle pulse after any update that reflects off an edge
module bounce_sprite #(
    parameter int          BOX_W     = 32,
    parameter int          BOX_H     = 32,
    parameter int          STEP      = 2,
    parameter int          FRAME_DIV = 1,
    parameter int          H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int          V_ACTIVE  = vga_pkg::V_ACTIVE,
    parameter logic [11:0] BG_COLOR  = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [9:0]  row,
    input  logic [9:0]  col,
    output logic [11:0] rgb,
    output logic        bounce
);

    import vga_pkg::*;

    localparam int XMAX  = H_ACTIVE - BOX_W;
    localparam int YMAX  = V_ACTIVE - BOX_H;
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic             eof, tick, upd, any_flip;
    logic             flip_x, flip_y;
    logic [9:0]       x_pos, y_pos;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic             bounce_q, bounce_d;
    logic [10:0]      col_x, row_y, x_hi, y_hi;
    logic             in_box;

    bounce_axis #(.LIMIT(XMAX), .STEP(STEP)) u_x (
        .clk   (clk),
        .reset (reset),
        .upd   (upd),
        .pos   (x_pos),
        .flip  (flip_x)
    );

    bounce_axis #(.LIMIT(YMAX), .STEP(STEP)) u_y (
        .clk   (clk),
        .reset (reset),
        .upd   (upd),
        .pos   (y_pos),
        .flip  (flip_y)
    );

    // The driver parks row/col at 0,0 during blanking, so the last active
    // pixel is the only unambiguous once-per-frame marker.
    always_comb begin
        eof      = (row == 10'(V_ACTIVE - 1)) && (col == 10'(H_ACTIVE - 1));
        tick     = enable && eof;
        upd      = tick && (div_q == DIV_W'(FRAME_DIV - 1));
        div_d    = div_q;
        if (tick) begin
            div_d = upd ? '0 : div_q + DIV_W'(1);
        end
        // A corner hit flips both axes but still counts as one bounce.
        any_flip = flip_x || flip_y;
        idx_d    = idx_q + 2'(any_flip);
        bounce_d = any_flip;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q    <= '0;
            idx_q    <= '0;
            bounce_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            bounce_q <= bounce_d;
        end
    end

    // 11-bit compares so x+BOX_W near the right edge cannot wrap.
    always_comb begin
        col_x  = {1'b0, col};
        row_y  = {1'b0, row};
        x_hi   = {1'b0, x_pos} + 11'(BOX_W);
        y_hi   = {1'b0, y_pos} + 11'(BOX_H);
        in_box = (col_x >= {1'b0, x_pos}) && (col_x < x_hi) &&
                 (row_y >= {1'b0, y_pos}) && (row_y < y_hi);
        rgb    = in_box ? PALETTE[idx_q] : BG_COLOR;
    end

    assign bounce = bounce_q;

endmodule
